// File: rtl/imem_loader.sv
// Streams a length-prefixed program in 4-bit nibbles into instruction memory while holding the CPU in reset.
// Define IMEM_LOADER_CKSUM_EN to require a trailing XOR checksum word after the program.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [3:0]        nib_in,
    input  logic              nib_valid,
    output logic              nib_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_count
);

`ifdef IMEM_LOADER_CKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CKSUM, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DONE, S_ERR} state_t;
`endif

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [32:0]       CAPACITY = 33'd1 << ADDR_W;

    state_t      state;
    logic [1:0]  nib_cnt;
    logic [15:0] len_q;
    logic [11:0] asm_q;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [15:0] xor_q;
`endif

    logic        fire;
    logic        last_nib;
    logic [15:0] nib_word;
    logic [15:0] len_word;
    logic [15:0] count_next;

    // A length may equal the capacity exactly; only strictly larger values abort.
    function automatic logic len_overflow(input logic [15:0] n);
        return 33'(n) > CAPACITY;
    endfunction

    assign fire       = nib_valid & nib_ready;
    assign last_nib   = (nib_cnt == 2'd3);
    assign nib_word   = {asm_q, nib_in};
    assign len_word   = {len_q[11:0], nib_in};
    assign count_next = word_count + 16'd1;

    always_ff @(posedge Clk) begin
        if (reset) begin
            state      <= S_IDLE;
            nib_ready  <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= BASE;
            wr_data    <= 16'd0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= 16'd0;
            nib_cnt    <= 2'd0;
            len_q      <= 16'd0;
        end else begin
            wr_en <= 1'b0;
            if (load_start && (state == S_IDLE || state == S_DONE || state == S_ERR)) begin
                state      <= S_LEN;
                nib_ready  <= 1'b1;
                cpu_hold   <= 1'b1;
                done       <= 1'b0;
                err        <= 1'b0;
                word_count <= 16'd0;
                nib_cnt    <= 2'd0;
`ifdef IMEM_LOADER_CKSUM_EN
                xor_q      <= 16'd0;
`endif
            end else begin
                if (fire) begin
                    nib_cnt <= nib_cnt + 2'd1;
                end
                case (state)
                    S_LEN: begin
                        if (fire) begin
                            len_q <= len_word;
                            if (last_nib) begin
                                if (len_overflow(len_word)) begin
                                    state     <= S_ERR;
                                    err       <= 1'b1;
                                    nib_ready <= 1'b0;
                                end else if (len_word == 16'd0) begin
`ifdef IMEM_LOADER_CKSUM_EN
                                    state     <= S_CKSUM;
`else
                                    state     <= S_DONE;
                                    done      <= 1'b1;
                                    cpu_hold  <= 1'b0;
                                    nib_ready <= 1'b0;
`endif
                                end else begin
                                    state <= S_DATA;
                                end
                            end
                        end
                    end
                    S_DATA: begin
                        if (fire) begin
                            asm_q <= nib_word[11:0];
                            // Word complete: present the write on the following cycle.
                            if (last_nib) begin
                                wr_en      <= 1'b1;
                                wr_data    <= nib_word;
                                wr_addr    <= BASE + ADDR_W'(word_count);
                                word_count <= count_next;
`ifdef IMEM_LOADER_CKSUM_EN
                                xor_q      <= xor_q ^ nib_word;
                                if (count_next == len_q) begin
                                    state <= S_CKSUM;
                                end
`else
                                if (count_next == len_q) begin
                                    state     <= S_DONE;
                                    done      <= 1'b1;
                                    cpu_hold  <= 1'b0;
                                    nib_ready <= 1'b0;
                                end
`endif
                            end
                        end
                    end
`ifdef IMEM_LOADER_CKSUM_EN
                    S_CKSUM: begin
                        if (fire) begin
                            asm_q <= nib_word[11:0];
                            if (last_nib) begin
                                nib_ready <= 1'b0;
                                if (nib_word == xor_q) begin
                                    state    <= S_DONE;
                                    done     <= 1'b1;
                                    cpu_hold <= 1'b0;
                                end else begin
                                    state <= S_ERR;
                                    err   <= 1'b1;
                                end
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule
